// File: rtl/dc_pkg.sv
// dc_pkg: widths, request source and FSM state types shared by the memory write path.
package dc_pkg;
    localparam int ID_W   = 16;
    localparam int ADDR_W = 64;
    localparam int DATA_W = 512;
    typedef enum logic {SRC_FILL = 1'b0, SRC_HIT = 1'b1} src_e;
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant with a registered priority pointer.
module rr_arb2
    import dc_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_req_f,
    input  logic i_req_h,
    output logic o_rdy_f,
    output logic o_rdy_h,
    output logic o_gnt,
    output src_e o_gnt_src
);
    src_e r_ptr;
    logic w_gnt_f;
    logic w_gnt_h;

    // A lone requester wins regardless of the pointer; the pointer only breaks ties.
    assign o_rdy_f   = i_en & ((r_ptr == SRC_FILL) | ~i_req_h);
    assign o_rdy_h   = i_en & ((r_ptr == SRC_HIT) | ~i_req_f);
    assign w_gnt_f   = i_req_f & o_rdy_f;
    assign w_gnt_h   = i_req_h & o_rdy_h;
    assign o_gnt     = w_gnt_f | w_gnt_h;
    assign o_gnt_src = w_gnt_h ? SRC_HIT : SRC_FILL;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_ptr <= SRC_FILL;
        else if (o_gnt)
            r_ptr <= w_gnt_h ? SRC_FILL : SRC_HIT;
    end
endmodule

// File: rtl/mem_wr_arbiter.sv
// mem_wr_arbiter: shares the memory AW/W channels between fill and write-hit sources,
// holding one registered address+data slot until both handshakes complete.
module mem_wr_arbiter #(
    parameter int ID_W   = dc_pkg::ID_W,
    parameter int ADDR_W = dc_pkg::ADDR_W,
    parameter int DATA_W = dc_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ID_W-1:0]   f_id_i,
    input  logic [ADDR_W-1:0] f_addr_i,
    input  logic [DATA_W-1:0] f_data_i,
    input  logic              f_valid_i,
    output logic              f_ready_o,
    input  logic [ID_W-1:0]   h_id_i,
    input  logic [ADDR_W-1:0] h_addr_i,
    input  logic [DATA_W-1:0] h_data_i,
    input  logic              h_valid_i,
    output logic              h_ready_o,
    output logic [ID_W-1:0]   m_awid_o,
    output logic [ADDR_W-1:0] m_awaddr_o,
    output logic              m_awvalid_o,
    input  logic              m_awready_i,
    output logic [ID_W-1:0]   m_wid_o,
    output logic [DATA_W-1:0] m_wdata_o,
    output logic              m_wvalid_o,
    input  logic              m_wready_i,
    output logic              gnt_src_o
);
    import dc_pkg::*;

    state_e            r_state;
    state_e            w_next;
    logic [ID_W-1:0]   r_id;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    src_e              r_src;
    logic              r_aw_done;
    logic              r_w_done;
    logic              w_gnt;
    src_e              w_gnt_src;
    logic              w_aw_hs;
    logic              w_w_hs;
    logic              w_aw_done;
    logic              w_w_done;

    rr_arb2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_en      (r_state == IDLE),
        .i_req_f   (f_valid_i),
        .i_req_h   (h_valid_i),
        .o_rdy_f   (f_ready_o),
        .o_rdy_h   (h_ready_o),
        .o_gnt     (w_gnt),
        .o_gnt_src (w_gnt_src)
    );

    // Valids come from registered state only, never from the memory readies.
    assign m_awvalid_o = (r_state == BUSY) & ~r_aw_done;
    assign m_wvalid_o  = (r_state == BUSY) & ~r_w_done;
    assign m_awid_o    = r_id;
    assign m_wid_o     = r_id;
    assign m_awaddr_o  = r_addr;
    assign m_wdata_o   = r_data;
    assign gnt_src_o   = r_src;
    assign w_aw_hs     = m_awvalid_o & m_awready_i;
    assign w_w_hs      = m_wvalid_o & m_wready_i;
    assign w_aw_done   = r_aw_done | w_aw_hs;
    assign w_w_done    = r_w_done | w_w_hs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (r_state == IDLE)
            w_next = w_gnt ? BUSY : IDLE;
        else
            w_next = (w_aw_done & w_w_done) ? IDLE : BUSY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id      <= '0;
            r_addr    <= '0;
            r_data    <= '0;
            r_src     <= SRC_FILL;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else if (w_gnt) begin
            r_id      <= (w_gnt_src == SRC_HIT) ? h_id_i : f_id_i;
            r_addr    <= (w_gnt_src == SRC_HIT) ? h_addr_i : f_addr_i;
            r_data    <= (w_gnt_src == SRC_HIT) ? h_data_i : f_data_i;
            r_src     <= w_gnt_src;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else if (r_state == BUSY) begin
            r_aw_done <= w_aw_done;
            r_w_done  <= w_w_done;
        end
    end
endmodule
